wb_pipelined_mem_responder: RTL and testbench

Pipelined Wishbone responder that implements the memory side of the processor wrapper's instruction and data buses. Each of `core_*` and `data_mem_*` gets its own instance, so simulation and FPGA builds can run a core against local RAM without the Controller. The block zero-initialises its memory after reset, then accepts one request per cycle. Every accepted request is answered with exactly one acknowledge after a fixed latency.

---
 rtl/wb_pipelined_mem_responder_if.sv | 26 ++
 rtl/wb_pipelined_mem_responder.sv | 149 ++++++++++++++
 tb/tb_wb_pipelined_mem_responder.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_pipelined_mem_responder_if.sv
// Wishbone pipelined bus bundle between a core-side master and the memory responder.
// Latency: none (wires only).
// Backpressure: carried by wb_stall_o from slave to master.
// Signals: cyc/stb/we/sel/addr/data_i are driven by the master; data_o/ack/stall/err by the slave.
interface wb_pipelined_mem_responder_if;
    logic        wb_cyc_i;
    logic        wb_stb_i;
    logic        wb_we_i;
    logic [3:0]  wb_sel_i;
    logic [31:0] wb_addr_i;
    logic [31:0] wb_data_i;
    logic [31:0] wb_data_o;
    logic        wb_ack_o;
    logic        wb_stall_o;
    logic        wb_err_o;

    modport master (
        output wb_cyc_i, wb_stb_i, wb_we_i, wb_sel_i, wb_addr_i, wb_data_i,
        input  wb_data_o, wb_ack_o, wb_stall_o, wb_err_o
    );

    modport slave (
        input  wb_cyc_i, wb_stb_i, wb_we_i, wb_sel_i, wb_addr_i, wb_data_i,
        output wb_data_o, wb_ack_o, wb_stall_o, wb_err_o
    );
endinterface

// File: rtl/wb_pipelined_mem_responder.sv
// Pipelined Wishbone memory responder: zero-fills RAM after reset, then serves one request per cycle.
// Latency: LATENCY cycles from acceptance to ack (1..4), fixed, in order.
// Backpressure: stalls only while initialising; never stalls in READY, acks never stall.
//
// Ports: sys_clk (only clock), rst_n (async active-low), wb (slave modport of
// wb_pipelined_mem_responder_if). Optional macro WB_RESP_ERR_EN: requests at or above
// MEM_WORDS*4 are accepted, have no memory effect and answer with wb_err_o instead of wb_ack_o.
module wb_pipelined_mem_responder #(
    parameter int MEM_WORDS = 1024,
    parameter int LATENCY   = 1
) (
    input  logic                         sys_clk,
    input  logic                         rst_n,
    wb_pipelined_mem_responder_if.slave  wb
);

    localparam int AW = $clog2(MEM_WORDS);

    typedef enum logic {INIT, READY} state_t;

    state_t              state;
    state_t              state_nxt;
    logic [AW-1:0]       init_cnt;
    logic                init_we;
    logic                stall;

    logic [31:0]         mem [MEM_WORDS];

    logic                accept;
    logic [AW-1:0]       idx;
    logic                oor;
    logic [31:0]         rd_dat;
    logic                addr_unused;

    logic [LATENCY-1:0]  pipe_vld;
    logic [LATENCY-1:0]  pipe_err;
    logic [31:0]         pipe_dat [LATENCY];

    // ---------------- FSM: state register ----------------
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= INIT;
        end else begin
            state <= state_nxt;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_nxt = state;
        case (state)
            INIT:    if (init_cnt == AW'(MEM_WORDS - 1)) state_nxt = READY;
            READY:   state_nxt = READY;
            default: state_nxt = INIT;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    // Stall decodes the state register only, so it has no path from the bus inputs.
    always_comb begin
        stall   = 1'b1;
        init_we = 1'b0;
        case (state)
            INIT: begin
                stall   = 1'b1;
                init_we = 1'b1;
            end
            READY: begin
                stall   = 1'b0;
                init_we = 1'b0;
            end
            default: begin
                stall   = 1'b1;
                init_we = 1'b0;
            end
        endcase
    end

    // Init word counter; wraps back to 0 on the last word, which is harmless in READY.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            init_cnt <= '0;
        end else if (init_we) begin
            init_cnt <= init_cnt + 1'b1;
        end
    end

    // ---------------- request decode ----------------
    assign idx    = wb.wb_addr_i[AW+1:2];
    assign accept = wb.wb_cyc_i & wb.wb_stb_i & ~stall;
    assign rd_dat = mem[idx];

`ifdef WB_RESP_ERR_EN
    assign oor = |wb.wb_addr_i[31:AW+2];
`else
    // Upper address bits simply alias onto the word index.
    assign oor = 1'b0;
`endif

    assign addr_unused = ^{wb.wb_addr_i[1:0], wb.wb_addr_i[31:AW+2]};

    // ---------------- memory ----------------
    // Init and bus writes are mutually exclusive: acceptance needs READY.
    always_ff @(posedge sys_clk) begin
        if (init_we) begin
            mem[init_cnt] <= '0;
        end else if (accept && wb.wb_we_i && !oor) begin
            for (int b = 0; b < 4; b++) begin
                if (wb.wb_sel_i[b]) begin
                    mem[idx][8*b +: 8] <= wb.wb_data_i[8*b +: 8];
                end
            end
        end
    end

    // ---------------- response pipeline ----------------
    // Dropping cyc flushes every outstanding response; committed writes stay in memory.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe_vld <= '0;
            pipe_err <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                pipe_dat[i] <= '0;
            end
        end else if (!wb.wb_cyc_i) begin
            pipe_vld <= '0;
            pipe_err <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                pipe_dat[i] <= '0;
            end
        end else begin
            pipe_vld[0] <= accept & ~oor;
            pipe_err[0] <= accept & oor;
            pipe_dat[0] <= (accept && !wb.wb_we_i && !oor) ? rd_dat : 32'h0;
            for (int i = 1; i < LATENCY; i++) begin
                pipe_vld[i] <= pipe_vld[i-1];
                pipe_err[i] <= pipe_err[i-1];
                pipe_dat[i] <= pipe_dat[i-1];
            end
        end
    end

    // Responses are qualified by cyc so a response landing in the abort cycle is never seen.
    assign wb.wb_ack_o   = pipe_vld[LATENCY-1] & wb.wb_cyc_i;
    assign wb.wb_err_o   = pipe_err[LATENCY-1] & wb.wb_cyc_i;
    assign wb.wb_data_o  = wb.wb_ack_o ? pipe_dat[LATENCY-1] : 32'h0;
    assign wb.wb_stall_o = stall;

endmodule

// File: tb/tb_wb_pipelined_mem_responder.sv
// Self-checking bench for wb_pipelined_mem_responder (MEM_WORDS=16, LATENCY=3).
// Directed test-plan scenarios followed by random traffic, all compared cycle by cycle
// against a transaction-level memory/response model.
module tb_wb_pipelined_mem_responder;

    localparam int MW  = 16;
    localparam int LAT = 3;

    logic sys_clk = 1'b0;
    logic rst_n;

    wb_pipelined_mem_responder_if wb();

    wb_pipelined_mem_responder #(.MEM_WORDS(MW), .LATENCY(LAT)) dut (
        .sys_clk (sys_clk),
        .rst_n   (rst_n),
        .wb      (wb)
    );

    always #5 sys_clk = ~sys_clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        int          due;
        logic        err;
        logic [31:0] dat;
    } rsp_t;

    typedef struct {
        int          at;
        logic [31:0] dat;
    } obs_t;

    logic [31:0] ref_mem [MW];
    rsp_t        pend[$];
    obs_t        obs_q[$];
    int          edge_cnt  = 0;
    int          since_rst = 0;
    int          err_seen  = 0;

    function automatic bit ref_oor(input logic [31:0] a);
`ifdef WB_RESP_ERR_EN
        return a >= 32'(MW * 4);
`else
        return 1'b0;
`endif
    endfunction

    task automatic ref_clear();
        for (int i = 0; i < MW; i++) ref_mem[i] = 32'h0;
        pend.delete();
        since_rst = 0;
    endtask

    task automatic compare();
        rsp_t        r;
        logic        ea;
        logic        ee;
        logic [31:0] ed;
        ea = 1'b0;
        ee = 1'b0;
        ed = 32'h0;
        if (pend.size() > 0 && pend[0].due == edge_cnt) begin
            r  = pend.pop_front();
            ee = r.err;
            ea = !r.err;
            ed = r.err ? 32'h0 : r.dat;
        end
        check("ack",   {31'b0, wb.wb_ack_o},   {31'b0, ea});
        check("err",   {31'b0, wb.wb_err_o},   {31'b0, ee});
        check("data",  wb.wb_data_o,           ed);
        check("stall", {31'b0, wb.wb_stall_o}, {31'b0, (!rst_n || since_rst < MW)});
        if (wb.wb_ack_o) obs_q.push_back('{edge_cnt, wb.wb_data_o});
        if (wb.wb_err_o) err_seen++;
    endtask

    // One bus cycle: drive at the negedge, update the model for the coming edge,
    // then compare outputs at the following negedge.
    task automatic tick(input bit c, input bit s, input bit w, input logic [3:0] sel,
                        input logic [31:0] a, input logic [31:0] d);
        rsp_t r;
        int   idx;
        bit   stall_exp;
        wb.wb_cyc_i  = c;
        wb.wb_stb_i  = s;
        wb.wb_we_i   = w;
        wb.wb_sel_i  = sel;
        wb.wb_addr_i = a;
        wb.wb_data_i = d;
        stall_exp = !rst_n || since_rst < MW;
        if (c && s && !stall_exp) begin
            idx   = int'((a >> 2) % MW);
            r.due = edge_cnt + LAT;
            r.err = ref_oor(a);
            r.dat = 32'h0;
            if (!r.err) begin
                if (w) begin
                    for (int b = 0; b < 4; b++)
                        if (sel[b]) ref_mem[idx][8*b +: 8] = d[8*b +: 8];
                end else begin
                    r.dat = ref_mem[idx];
                end
            end
            pend.push_back(r);
        end
        if (!c) pend.delete();
        @(posedge sys_clk);
        edge_cnt++;
        if (rst_n) since_rst++;
        @(negedge sys_clk);
        compare();
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] sel);
        tick(1, 1, 1, sel, a, d);
    endtask

    task automatic rd(input logic [31:0] a);
        tick(1, 1, 0, 4'hF, a, 32'h0);
    endtask

    task automatic drain();
        for (int i = 0; i <= LAT; i++) tick(1, 0, 0, 4'h0, 32'h0, 32'h0);
    endtask

    initial begin
        int          n;
        int          a0;
        logic [31:0] ra;
        logic [3:0]  rs;

        wb.wb_cyc_i  = 1'b0;
        wb.wb_stb_i  = 1'b0;
        wb.wb_we_i   = 1'b0;
        wb.wb_sel_i  = 4'h0;
        wb.wb_addr_i = 32'h0;
        wb.wb_data_i = 32'h0;
        rst_n = 1'b1;
        ref_clear();
        #1 rst_n = 1'b0;
        #1;
        check("rst_ack",   {31'b0, wb.wb_ack_o},   32'h0);
        check("rst_err",   {31'b0, wb.wb_err_o},   32'h0);
        check("rst_stall", {31'b0, wb.wb_stall_o}, 32'h1);
        check("rst_data",  wb.wb_data_o,           32'h0);
        @(negedge sys_clk);
        tick(0, 0, 0, 4'h0, 32'h0, 32'h0);
        rst_n = 1'b1;

        // INIT length: stall high for exactly MW cycles after reset release
        n = 0;
        while (wb.wb_stall_o && n < 40) begin
            n++;
            tick(1, 0, 0, 4'h0, 32'h0, 32'h0);
        end
        check("init_cycles", 32'(n), 32'(MW));

        // last word reads zero after INIT
        obs_q.delete();
        rd(32'h3C);
        drain();
        check("init_rd_cnt", 32'(obs_q.size()), 32'h1);
        if (obs_q.size() > 0) check("init_rd_dat", obs_q[0].dat, 32'h0);

        // byte-lane merge with read-after-write
        obs_q.delete();
        wr(32'h8, 32'hDEADBEEF, 4'hF);
        wr(32'h8, 32'h000000AA, 4'h1);
        rd(32'h8);
        drain();
        check("merge_cnt", 32'(obs_q.size()), 32'h3);
        if (obs_q.size() == 3) begin
            check("merge_consec", 32'(obs_q[2].at - obs_q[0].at), 32'h2);
            check("merge_dat", obs_q[2].dat, 32'hDEADBEAA);
        end

        // latency: four back-to-back reads
        for (int i = 0; i < 4; i++) wr(32'(4 * i), 32'(4 * i), 4'hF);
        drain();
        obs_q.delete();
        rd(32'h0);
        a0 = edge_cnt;
        rd(32'h4);
        rd(32'h8);
        rd(32'hC);
        drain();
        check("lat_cnt", 32'(obs_q.size()), 32'h4);
        for (int i = 0; i < 4 && i < obs_q.size(); i++) begin
            check("lat_at",  32'(obs_q[i].at), 32'(a0 + LAT - 1 + i));
            check("lat_dat", obs_q[i].dat,      32'(4 * i));
        end

        // abort: write + read accepted, then cyc drops with a simultaneous strobe
        obs_q.delete();
        wr(32'h14, 32'h55AA1234, 4'hF);
        rd(32'h14);
        tick(0, 1, 0, 4'hF, 32'h18, 32'h0);
        drain();
        check("abort_noack", 32'(obs_q.size()), 32'h0);
        rd(32'h14);
        drain();
        check("abort_cnt", 32'(obs_q.size()), 32'h1);
        if (obs_q.size() > 0) check("abort_commit", obs_q[0].dat, 32'h55AA1234);

        // out-of-range read
        wr(32'h0, 32'h0BADF00D, 4'hF);
        drain();
        obs_q.delete();
        err_seen = 0;
        rd(32'h40);
        drain();
`ifdef WB_RESP_ERR_EN
        check("oor_err", 32'(err_seen), 32'h1);
        check("oor_noack", 32'(obs_q.size()), 32'h0);
`else
        check("oor_noerr", 32'(err_seen), 32'h0);
        check("oor_alias_cnt", 32'(obs_q.size()), 32'h1);
        if (obs_q.size() > 0) check("oor_alias", obs_q[0].dat, 32'h0BADF00D);
`endif

        // random traffic
        for (int i = 0; i < 400; i++) begin
            ra = $urandom;
            if ($urandom_range(0, 3) != 0) ra = ra & 32'h7F;
            rs = 4'($urandom_range(0, 15));
            tick($urandom_range(0, 15) != 0, $urandom_range(0, 3) != 0,
                 $urandom_range(0, 1) == 1, rs, ra, $urandom);
        end
        drain();

        // reset with two responses outstanding
        rd(32'h8);
        rd(32'h14);
        rst_n = 1'b0;
        ref_clear();
        #1;
        check("mid_rst_ack",   {31'b0, wb.wb_ack_o},   32'h0);
        check("mid_rst_stall", {31'b0, wb.wb_stall_o}, 32'h1);
        @(negedge sys_clk);
        tick(1, 0, 0, 4'h0, 32'h0, 32'h0);
        rst_n = 1'b1;
        for (int i = 0; i < MW; i++) tick(1, 0, 0, 4'h0, 32'h0, 32'h0);
        obs_q.delete();
        rd(32'h8);
        rd(32'h14);
        drain();
        check("post_rst_cnt", 32'(obs_q.size()), 32'h2);
        for (int i = 0; i < obs_q.size(); i++) check("post_rst_zero", obs_q[i].dat, 32'h0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
